spi_flash_arbiter: RTL and testbench
====================================

Name: spi_flash_arbiter

Overview:
- Sequences the quad-SPI flash word reader and shares it between two requesters: the instruction-fetch port (I) and the data-read port (D).
- Gates all traffic until the reader reports init complete.
- Arbitrates round-robin between I and D, drives the reader's start/address, and waits for receive-done.
- Returns the 32-bit word with a one-cycle ack. Includes a watchdog on stuck reads.

Parameters:
- TIMEOUT_CYCLES, 256: clk cycles in BUSY without spi_recv_done before aborting with timeout_err.
- ADDR_W, 24: word-address width passed to the reader. The reader converts it to a byte address internally.

Ports:
- clk  in  1  system clock; block logic on posedge
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction read request; level, held until i_ack
- i_addr  in  ADDR_W  instruction word address; stable while i_req
- i_ack  out  1  one-cycle pulse; i_data valid this cycle
- i_data  out  32  instruction word
- d_req  in  1  data read request; level, held until d_ack
- d_addr  in  ADDR_W  data word address; stable while d_req
- d_ack  out  1  one-cycle pulse; d_data valid this cycle
- d_data  out  32  data word
- spi_addr  out  ADDR_W  address to reader
- spi_start  out  1  read trigger to reader
- spi_instr  in  32  word returned by reader
- spi_init_done  in  1  reader initialised and idle-capable
- spi_recv_done  in  1  reader word complete; registered on the reader's negedge
- busy  out  1  high in BUSY or RESP
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - state = WAIT_INIT.
  - All outputs 0: i_ack, d_ack, i_data, d_data, spi_addr, spi_start, busy, timeout_err.
  - Round-robin pointer = I.
- Reset mid-read: state returns to WAIT_INIT, spi_start drops, and any pending ack is discarded. Requesters re-request.
- WAIT_INIT:
  - No grants.
  - Go to IDLE on the first cycle spi_init_done = 1.
- IDLE:
  - Only I requesting: grant I. Only D requesting: grant D.
  - Both requesting: grant the port named by the RR pointer, then point the RR pointer at the other port.
  - On grant, the next cycle has spi_addr = the granted port's address and spi_start = 1. Latch grant_id. Go to BUSY.
  - A requester whose ack pulsed last cycle and whose req is still high is treated as a new request.
- BUSY:
  - spi_start stays high until spi_recv_done is seen. This is safe because the reader samples start only in its idle slot.
  - On spi_recv_done = 1:
    - Capture spi_instr into the granted port's data register.
    - spi_start <= 0. Go to RESP.
  - spi_addr stays constant throughout BUSY.
- RESP:
  - Pulse the granted port's ack for exactly one cycle. Go to IDLE.
  - The RESP cycle guarantees start is low for at least 2 clk before the reader's next start sample. No back-to-back retrigger.
- Latency, req to ack on a miss: 1 (grant) + reader time + 1 (capture) + 1 (RESP).
- Data hold: i_data and d_data hold their last value until overwritten. The non-granted port's data never changes.
- Timeout:
  - Count BUSY cycles. At TIMEOUT_CYCLES without spi_recv_done:
    - Set timeout_err.
    - spi_start <= 0.
    - Ack the granted port with data 32'hFFFF_FFFF. Go to IDLE.
  - Timeout counter width is clog2(TIMEOUT_CYCLES)+1 and saturates.
- spi_recv_done in IDLE or WAIT_INIT: ignored.
- spi_init_done falling outside WAIT_INIT: ignored. Only reset re-enters WAIT_INIT.
- At most one ack per cycle; i_ack and d_ack are never high together.

Optional Feature:
- Macro: SPI_ARB_LASTWORD_CACHE_EN.
- With the macro:
  - Hold one tag/data/valid entry, updated on every successful (non-timeout) read.
  - In IDLE, if the granted address equals the tag and valid = 1, skip the reader and go directly to RESP next cycle with the cached word. Latency is 2 cycles and spi_start stays 0.
  - Reset and timeout both clear valid.
- Without the macro: every request goes to the reader; there is no tag/valid logic.

Decomposition:
- Package spi_arb_pkg:
  - State enum {WAIT_INIT, IDLE, BUSY, RESP}.
  - Port id constants PORT_I = 0, PORT_D = 1.
  - TIMEOUT_DATA = 32'hFFFF_FFFF.
- Sub-module rr_arb2: 2-input round-robin grant with pointer update on accept. Combinational grant plus registered pointer.

Test Plan:
- Init gating: i_req = 1 with spi_init_done = 0 for 50 cycles -> spi_start stays 0 and no ack; raise spi_init_done -> spi_start rises 2 cycles later with spi_addr = i_addr.
- Single read: d_addr = 24'h000123; reader model returns 32'hDEADBEEF 20 cycles after start -> d_data = 32'hDEADBEEF, one d_ack pulse, i_ack = 0, i_data unchanged.
- Contention: i_req and d_req both held continuously -> grants alternate I, D, I, D over 4 reads, starting with I after reset; no simultaneous acks.
- Timeout with TIMEOUT_CYCLES = 16: reader never asserts done -> after 16 BUSY cycles, timeout_err = 1, ack with 32'hFFFFFFFF, spi_start = 0; the next read then completes normally while timeout_err stays 1.
- Reset mid-BUSY: assert reset 5 cycles after start -> all outputs 0, state WAIT_INIT, no stale ack after reset release.
- Cache (macro on): read i_addr = 24'h10 twice -> second ack 2 cycles after req with no spi_start; reading 24'h11 then goes to the reader.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types for the quad-SPI flash arbiter.
// FSM states, requester ids and the timeout fill word.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT,
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: combinational gnt_id from req,
// registered pointer flipped to the other port on accept.
module rr_arb2
  import spi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_id
);

  logic ptr;

  always_comb begin
    gnt_id = PORT_I;
    unique case (1'b1)
      (req == 2'b11): gnt_id = ptr;
      (req == 2'b10): gnt_id = PORT_D;
      default:        gnt_id = PORT_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PORT_I;
    end else if (accept) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares the SPI flash word reader between fetch (i_*) and data (d_*)
// ports; spi_* drive the reader, busy/timeout_err report status.
// Optional last-word cache: define SPI_ARB_LASTWORD_CACHE_EN.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic [31:0]       d_data,
  output logic [ADDR_W-1:0] spi_addr,
  output logic              spi_start,
  input  logic [31:0]       spi_instr,
  input  logic              spi_init_done,
  input  logic              spi_recv_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  logic              grant_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        req_v;
  logic              arb_take;
  logic              gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic              hit;
  logic [31:0]       hit_word;
  logic              to_hit;
  logic              wr_en;
  logic              wr_port;
  logic [31:0]       wr_val;

  // A port being acked this cycle is not yet a new request.
  assign req_v    = {d_req & ~d_ack, i_req & ~i_ack};
  assign arb_take = (state == IDLE) && (|req_v);
  assign gnt_addr = (gnt_id == PORT_D) ? d_addr : i_addr;
  assign to_hit   = (state == BUSY) && !spi_recv_done &&
                    (cnt >= CNT_LIM);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_v),
    .accept (arb_take),
    .gnt_id (gnt_id)
  );

`ifdef SPI_ARB_LASTWORD_CACHE_EN
  logic [ADDR_W-1:0] c_tag;
  logic [31:0]       c_word;
  logic              c_valid;

  assign hit      = c_valid && (c_tag == gnt_addr);
  assign hit_word = c_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_word  <= '0;
    end else if (state == BUSY) begin
      if (spi_recv_done) begin
        c_valid <= 1'b1;
        c_tag   <= spi_addr;
        c_word  <= spi_instr;
      end else if (to_hit) begin
        c_valid <= 1'b0;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  always_comb begin
    wr_en   = 1'b0;
    wr_val  = spi_instr;
    wr_port = grant_q;
    unique case (state)
      IDLE: begin
        wr_port = gnt_id;
        if (arb_take && hit) begin
          wr_en  = 1'b1;
          wr_val = hit_word;
        end
      end
      BUSY: begin
        if (spi_recv_done) begin
          wr_en = 1'b1;
        end else if (to_hit) begin
          wr_en  = 1'b1;
          wr_val = TIMEOUT_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_data <= '0;
      d_data <= '0;
    end else if (wr_en) begin
      if (wr_port == PORT_D) d_data <= wr_val;
      else                   i_data <= wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_INIT;
      grant_q     <= PORT_I;
      cnt         <= '0;
      spi_addr    <= '0;
      spi_start   <= 1'b0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        WAIT_INIT: begin
          if (spi_init_done) state <= IDLE;
        end
        IDLE: begin
          if (arb_take) begin
            grant_q <= gnt_id;
            busy    <= 1'b1;
            cnt     <= '0;
            if (hit) begin
              state <= RESP;
            end else begin
              state     <= BUSY;
              spi_addr  <= gnt_addr;
              spi_start <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (spi_recv_done) begin
            spi_start <= 1'b0;
            state     <= RESP;
          end else if (to_hit) begin
            // Abort: ack with the fill word straight from BUSY.
            timeout_err <= 1'b1;
            spi_start   <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
            if (grant_q == PORT_D) d_ack <= 1'b1;
            else                   i_ack <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (grant_q == PORT_D) d_ack <= 1'b1;
          else                   i_ack <= 1'b1;
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter with a behavioural reader.
// A second instance (TIMEOUT_CYCLES=16) covers the watchdog.
module tb_spi_flash_arbiter;
  import spi_arb_pkg::*;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic          d_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   spi_instr = '0;
  logic          spi_init_done = 1'b0;
  logic          spi_recv_done = 1'b0;
  logic          i_ack, d_ack, spi_start, busy, timeout_err;
  logic [31:0]   i_data, d_data;
  logic [AW-1:0] spi_addr;

  logic          t_done = 1'b0;
  logic [31:0]   t_instr = '0;
  logic          t_i_ack, t_d_ack, t_spi_start, t_busy, t_err;
  logic [31:0]   t_i_data, t_d_data;
  logic [AW-1:0] t_spi_addr;

  int          vec = 0;
  int          bad = 0;
  logic        rd_hang = 1'b0;
  logic        rd_fixed = 1'b0;
  logic [31:0] rd_word = '0;
  int          rd_lat = 20;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.TIMEOUT_CYCLES(256), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_data(d_data),
    .spi_addr(spi_addr), .spi_start(spi_start),
    .spi_instr(spi_instr), .spi_init_done(spi_init_done),
    .spi_recv_done(spi_recv_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  spi_flash_arbiter #(.TIMEOUT_CYCLES(16), .ADDR_W(AW)) dut_to (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(t_i_ack), .i_data(t_i_data),
    .d_req(d_req), .d_addr(d_addr), .d_ack(t_d_ack), .d_data(t_d_data),
    .spi_addr(t_spi_addr), .spi_start(t_spi_start),
    .spi_instr(t_instr), .spi_init_done(spi_init_done),
    .spi_recv_done(t_done),
    .busy(t_busy), .timeout_err(t_err)
  );

  // Reader: answers rd_lat cycles after it first sees start.
  always begin
    @(negedge clk);
    if (spi_start && !rd_hang && !reset) begin
      for (int k = 1; k < rd_lat; k++) @(negedge clk);
      spi_instr = rd_fixed ? rd_word : {8'h5A, spi_addr};
      spi_recv_done = 1'b1;
      @(negedge clk);
      spi_recv_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      vec++;
      if (i_ack && d_ack) begin
        bad++;
        $display("FAIL ack_onehot: i_ack=%b d_ack=%b, required not both",
                 i_ack, d_ack);
      end
    end
  end

  task automatic do_reset();
    reset  = 1'b1;
    i_req  = 1'b0;
    d_req  = 1'b0;
    t_done = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ack(output int cyc, output logic [1:0] who);
    cyc = -1;
    who = 2'b00;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        cyc = k;
        who = {d_ack, i_ack};
        break;
      end
    end
  endtask

  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (spi_start) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({i_ack, d_ack, spi_start, busy, timeout_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b, required 00000",
               {i_ack, d_ack, spi_start, busy, timeout_err});
    end
    vec++;
    if ({i_data, d_data} !== 64'h0) begin
      bad++;
      $display("FAIL reset_data: got %h %h, required 0 0", i_data, d_data);
    end
    vec++;
    if (spi_addr !== '0) begin
      bad++;
      $display("FAIL reset_addr: got %h, required 0", spi_addr);
    end
    vec++;
    if (dut.state !== WAIT_INIT) begin
      bad++;
      $display("FAIL reset_state: got %0d, required WAIT_INIT",
               dut.state);
    end
    reset = 1'b0;
  endtask

  task automatic test_init_gate();
    logic seen_s, seen_a;
    int cyc;
    logic [1:0] who;
    seen_s = 1'b0;
    seen_a = 1'b0;
    i_addr = 24'h000ABC;
    i_req  = 1'b1;
    repeat (50) begin
      @(negedge clk);
      seen_s |= spi_start;
      seen_a |= i_ack | d_ack;
    end
    vec++;
    if (seen_s !== 1'b0 || seen_a !== 1'b0) begin
      bad++;
      $display("FAIL init_gate: start=%b ack=%b, required 0 0",
               seen_s, seen_a);
    end
    spi_init_done = 1'b1;
    @(negedge clk);
    vec++;
    if (spi_start !== 1'b0) begin
      bad++;
      $display("FAIL init_early: start=%b, required 0", spi_start);
    end
    @(negedge clk);
    vec++;
    if (spi_start !== 1'b1 || spi_addr !== 24'h000ABC) begin
      bad++;
      $display("FAIL init_start: start=%b addr=%h, required 1 000abc",
               spi_start, spi_addr);
    end
    wait_ack(cyc, who);
    i_req = 1'b0;
    vec++;
    if (who !== 2'b01 || i_data !== 32'h5A000ABC) begin
      bad++;
      $display("FAIL init_read: who=%b data=%h, required 01 5a000abc",
               who, i_data);
    end
  endtask

  task automatic test_single_read();
    int sc, cyc;
    logic [1:0] who;
    logic [31:0] i_keep;
    i_keep   = i_data;
    rd_fixed = 1'b1;
    rd_word  = 32'hDEADBEEF;
    rd_lat   = 20;
    d_addr   = 24'h000123;
    d_req    = 1'b1;
    wait_start(sc);
    vec++;
    if (sc < 0 || spi_addr !== 24'h000123) begin
      bad++;
      $display("FAIL single_start: cyc=%0d addr=%h, required >=0 000123",
               sc, spi_addr);
    end
    wait_ack(cyc, who);
    d_req = 1'b0;
    vec++;
    if (cyc !== 21 || who !== 2'b10) begin
      bad++;
      $display("FAIL single_ack: cyc=%0d who=%b, required 21 10",
               cyc, who);
    end
    vec++;
    if (d_data !== 32'hDEADBEEF || i_data !== i_keep) begin
      bad++;
      $display("FAIL single_data: d=%h i=%h, required deadbeef %h",
               d_data, i_data, i_keep);
    end
    @(negedge clk);
    vec++;
    if (d_ack !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse: d_ack=%b, required 0", d_ack);
    end
    rd_fixed = 1'b0;
  endtask

  task automatic test_contention();
    int cyc;
    logic [1:0] who;
    logic [1:0] exp_who;
    do_reset();
    rd_lat = 4;
    i_addr = 24'h000111;
    d_addr = 24'h000222;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_who = (n % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(cyc, who);
      vec++;
      if (who !== exp_who) begin
        bad++;
        $display("FAIL rr_grant%0d: who=%b, required %b",
                 n, who, exp_who);
      end
      vec++;
      if ((who == 2'b01 && i_data !== 32'h5A000111) ||
          (who == 2'b10 && d_data !== 32'h5A000222)) begin
        bad++;
        $display("FAIL rr_data%0d: i=%h d=%h", n, i_data, d_data);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc;
    logic seen, err_mid, busy_mid;
    do_reset();
    i_addr = 24'h000777;
    i_req  = 1'b1;
    seen   = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (t_spi_start) begin
        seen = 1'b1;
        break;
      end
    end
    vec++;
    if (seen !== 1'b1 || t_spi_addr !== 24'h000777) begin
      bad++;
      $display("FAIL to_start: seen=%b addr=%h, required 1 000777",
               seen, t_spi_addr);
    end
    cyc = -1;
    err_mid = 1'bx;
    busy_mid = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 15) begin
        err_mid  = t_err;
        busy_mid = t_busy;
      end
      if (t_i_ack || t_d_ack) begin
        cyc = k;
        break;
      end
    end
    i_req = 1'b0;
    vec++;
    if (cyc !== 16 || err_mid !== 1'b0 || busy_mid !== 1'b1) begin
      bad++;
      $display("FAIL to_latency: cyc=%0d err=%b busy=%b, required 16 0 1",
               cyc, err_mid, busy_mid);
    end
    vec++;
    if (t_err !== 1'b1 || t_i_ack !== 1'b1 ||
        t_i_data !== TIMEOUT_DATA || t_spi_start !== 1'b0) begin
      bad++;
      $display("FAIL to_abort: err=%b ack=%b data=%h start=%b",
               t_err, t_i_ack, t_i_data, t_spi_start);
    end
    d_addr  = 24'h000888;
    t_instr = 32'h12345678;
    d_req   = 1'b1;
    seen    = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (t_spi_start) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    t_done = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (t_d_ack) begin
        cyc = k;
        break;
      end
    end
    d_req = 1'b0;
    vec++;
    if (seen !== 1'b1 || cyc < 0 || t_d_data !== 32'h12345678) begin
      bad++;
      $display("FAIL to_recover: seen=%b cyc=%0d data=%h",
               seen, cyc, t_d_data);
    end
    vec++;
    if (t_err !== 1'b1 || t_i_data !== TIMEOUT_DATA) begin
      bad++;
      $display("FAIL to_sticky: err=%b i=%h, required 1 ffffffff",
               t_err, t_i_data);
    end
  endtask

  task automatic test_reset_mid_busy();
    int sc;
    logic seen_a;
    do_reset();
    rd_hang = 1'b1;
    i_addr  = 24'h000333;
    i_req   = 1'b1;
    wait_start(sc);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    vec++;
    if ({i_ack, d_ack, spi_start, busy, timeout_err} !== 5'b0 ||
        spi_addr !== '0) begin
      bad++;
      $display("FAIL rst_busy_out: ctl=%b addr=%h, required 0 0",
               {i_ack, d_ack, spi_start, busy, timeout_err}, spi_addr);
    end
    vec++;
    if (dut.state !== WAIT_INIT || sc < 0) begin
      bad++;
      $display("FAIL rst_busy_state: state=%0d sc=%0d", dut.state, sc);
    end
    @(negedge clk);
    reset  = 1'b0;
    seen_a = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen_a |= i_ack | d_ack | spi_start;
    end
    vec++;
    if (seen_a !== 1'b0) begin
      bad++;
      $display("FAIL rst_stale: activity=%b, required 0", seen_a);
    end
    rd_hang = 1'b0;
  endtask

  task automatic test_repeat_read();
    int cyc;
    logic [1:0] who;
    logic seen_s;
    do_reset();
    rd_lat = 4;
    i_addr = 24'h000010;
    i_req  = 1'b1;
    wait_ack(cyc, who);
    i_req = 1'b0;
    vec++;
    if (who !== 2'b01 || i_data !== 32'h5A000010) begin
      bad++;
      $display("FAIL rep_first: who=%b data=%h", who, i_data);
    end
    repeat (2) @(negedge clk);
    i_req  = 1'b1;
    seen_s = 1'b0;
    cyc    = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      seen_s |= spi_start;
      if (i_ack) begin
        cyc = k;
        break;
      end
    end
    i_req = 1'b0;
`ifdef SPI_ARB_LASTWORD_CACHE_EN
    vec++;
    if (cyc !== 2 || seen_s !== 1'b0) begin
      bad++;
      $display("FAIL cache_hit: cyc=%0d start=%b, required 2 0",
               cyc, seen_s);
    end
`else
    vec++;
    if (cyc !== 6 || seen_s !== 1'b1) begin
      bad++;
      $display("FAIL reread: cyc=%0d start=%b, required 6 1",
               cyc, seen_s);
    end
`endif
    vec++;
    if (i_data !== 32'h5A000010) begin
      bad++;
      $display("FAIL rep_data: got %h, required 5a000010", i_data);
    end
    i_addr = 24'h000011;
    i_req  = 1'b1;
    wait_start(cyc);
    vec++;
    if (cyc < 0 || spi_addr !== 24'h000011) begin
      bad++;
      $display("FAIL rep_miss: cyc=%0d addr=%h, required >=0 000011",
               cyc, spi_addr);
    end
    wait_ack(cyc, who);
    i_req = 1'b0;
    vec++;
    if (who !== 2'b01 || i_data !== 32'h5A000011) begin
      bad++;
      $display("FAIL rep_miss_data: who=%b data=%h", who, i_data);
    end
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_single_read();
    test_contention();
    test_timeout();
    test_reset_mid_busy();
    test_repeat_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
